alu_ctrl: RTL and testbench

//  ALU control decoder for the single-cycle MIPS-style datapath. Maps the 3-bit

---
 rtl/alu_ctrl.sv | 73 +++++++
 tb/tb_alu_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - ALU control decoder: aluop/funct to ALU select, registered copy and sticky error.
// Optional feature macro: ALU_CTRL_EXT_EN (adds R-type nor -> 3 and sltu -> 5).
module alu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] aluctrl,
  output logic       illegal,
  output logic [2:0] aluctrl_q,
  output logic       illegal_q,
  output logic       err_sticky
);

  localparam logic [2:0] SEL_AND = 3'd0;
  localparam logic [2:0] SEL_OR  = 3'd1;
  localparam logic [2:0] SEL_ADD = 3'd2;
  localparam logic [2:0] SEL_XOR = 3'd4;
  localparam logic [2:0] SEL_SUB = 3'd6;
  localparam logic [2:0] SEL_SLT = 3'd7;
`ifdef ALU_CTRL_EXT_EN
  localparam logic [2:0] SEL_NOR  = 3'd3;
  localparam logic [2:0] SEL_SLTU = 3'd5;
`endif

  // Unsupported encodings fall back to ADD so the datapath never sees an undefined select.
  always_comb begin
    aluctrl = SEL_ADD;
    illegal = 1'b0;
    case (aluop)
      3'b000: aluctrl = SEL_ADD;
      3'b001: aluctrl = SEL_SUB;
      3'b011: aluctrl = SEL_OR;
      3'b100: aluctrl = SEL_XOR;
      3'b010: begin
        case (funct)
          6'b100000: aluctrl = SEL_ADD;
          6'b100010: aluctrl = SEL_SUB;
          6'b100100: aluctrl = SEL_AND;
          6'b100101: aluctrl = SEL_OR;
          6'b100110: aluctrl = SEL_XOR;
          6'b101010: aluctrl = SEL_SLT;
`ifdef ALU_CTRL_EXT_EN
          6'b100111: aluctrl = SEL_NOR;
          6'b101011: aluctrl = SEL_SLTU;
`endif
          default: begin
            aluctrl = SEL_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        aluctrl = SEL_ADD;
        illegal = 1'b1;
      end
    endcase
  end

  // err_sticky samples illegal_q, so it trails the combinational flag by two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluctrl_q  <= 3'd0;
      illegal_q  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      aluctrl_q  <= aluctrl;
      illegal_q  <= illegal;
      err_sticky <= err_sticky | illegal_q;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - table-driven self-checking bench for alu_ctrl.
module tb_alu_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] aluop;
  logic [5:0] funct;
  logic [2:0] aluctrl;
  logic       illegal;
  logic [2:0] aluctrl_q;
  logic       illegal_q;
  logic       err_sticky;

  int n_checks;
  int n_fail;

  alu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .aluop      (aluop),
    .funct      (funct),
    .aluctrl    (aluctrl),
    .illegal    (illegal),
    .aluctrl_q  (aluctrl_q),
    .illegal_q  (illegal_q),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [2:0] exp_sel;
    logic       exp_ill;
  } vec_t;

  vec_t vecs[$];

  // Expected register state, advanced by hand at each posedge.
  logic [2:0] m_sel_q;
  logic       m_ill_q;
  logic       m_sticky;

`ifdef ALU_CTRL_EXT_EN
  localparam logic [2:0] EXP_NOR  = 3'd3;
  localparam logic [2:0] EXP_SLTU = 3'd5;
  localparam logic       EXP_XILL = 1'b0;
`else
  localparam logic [2:0] EXP_NOR  = 3'd2;
  localparam logic [2:0] EXP_SLTU = 3'd2;
  localparam logic       EXP_XILL = 1'b1;
`endif

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    aluop = v.op;
    funct = v.fn;
    #1;
    check($sformatf("v%0d aluctrl", idx), {5'd0, aluctrl}, {5'd0, v.exp_sel});
    check($sformatf("v%0d illegal", idx), {7'd0, illegal}, {7'd0, v.exp_ill});
    @(posedge clk);
    m_sticky = m_sticky | m_ill_q;
    m_sel_q  = v.exp_sel;
    m_ill_q  = v.exp_ill;
    #1;
    check($sformatf("v%0d aluctrl_q", idx), {5'd0, aluctrl_q}, {5'd0, m_sel_q});
    check($sformatf("v%0d illegal_q", idx), {7'd0, illegal_q}, {7'd0, m_ill_q});
    check($sformatf("v%0d err_sticky", idx), {7'd0, err_sticky}, {7'd0, m_sticky});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    aluop = 3'b000;
    funct = 6'b000000;
    m_sel_q  = 3'd0;
    m_ill_q  = 1'b0;
    m_sticky = 1'b0;

    // R-type sweep
    vecs.push_back('{3'b010, 6'b100000, 3'd2, 1'b0});
    vecs.push_back('{3'b010, 6'b100010, 3'd6, 1'b0});
    vecs.push_back('{3'b010, 6'b100100, 3'd0, 1'b0});
    vecs.push_back('{3'b010, 6'b100101, 3'd1, 1'b0});
    vecs.push_back('{3'b010, 6'b101010, 3'd7, 1'b0});
    vecs.push_back('{3'b010, 6'b100110, 3'd4, 1'b0});
    // non-R ops, funct ignored
    vecs.push_back('{3'b000, 6'b100110, 3'd2, 1'b0});
    vecs.push_back('{3'b001, 6'b100110, 3'd6, 1'b0});
    vecs.push_back('{3'b011, 6'b100110, 3'd1, 1'b0});
    vecs.push_back('{3'b100, 6'b100110, 3'd4, 1'b0});
    vecs.push_back('{3'b100, 6'b000000, 3'd4, 1'b0});
    // extension codes
    vecs.push_back('{3'b010, 6'b100111, EXP_NOR,  EXP_XILL});
    vecs.push_back('{3'b010, 6'b101011, EXP_SLTU, EXP_XILL});
    // flush any extension-induced error with a reset before the plain illegal cases
    vecs.push_back('{3'b000, 6'b000000, 3'd2, 1'b0});

    #3;
    check("reset aluctrl_q", {5'd0, aluctrl_q}, 8'd0);
    check("reset illegal_q", {7'd0, illegal_q}, 8'd0);
    check("reset err_sticky", {7'd0, err_sticky}, 8'd0);
    check("reset comb aluctrl", {5'd0, aluctrl}, 8'd2);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // clean restart so the illegal sequence starts from err_sticky=0
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_sel_q = 3'd0; m_ill_q = 1'b0; m_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // illegal encodings, then legal ops: sticky must set two edges later and hold
    apply_vec('{3'b111, 6'b100000, 3'd2, 1'b1}, 100);
    apply_vec('{3'b010, 6'b000000, 3'd2, 1'b1}, 101);
    apply_vec('{3'b101, 6'b100010, 3'd2, 1'b1}, 102);
    apply_vec('{3'b110, 6'b100010, 3'd2, 1'b1}, 103);
    apply_vec('{3'b001, 6'b000000, 3'd6, 1'b0}, 104);
    apply_vec('{3'b011, 6'b000000, 3'd1, 1'b0}, 105);
    check("sticky held", {7'd0, err_sticky}, 8'd1);

    // registered-path latency: slt visible at once, aluctrl_q only after the edge
    @(negedge clk);
    aluop = 3'b010;
    funct = 6'b101010;
    #1;
    check("lat comb", {5'd0, aluctrl}, 8'd7);
    check("lat q before edge", {5'd0, aluctrl_q}, 8'd1);
    @(posedge clk);
    #1;
    check("lat q after edge", {5'd0, aluctrl_q}, 8'd7);

    // async reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async aluctrl_q", {5'd0, aluctrl_q}, 8'd0);
    check("async illegal_q", {7'd0, illegal_q}, 8'd0);
    check("async err_sticky", {7'd0, err_sticky}, 8'd0);
    aluop = 3'b001;
    #1;
    check("async comb follows", {5'd0, aluctrl}, 8'd6);
    @(posedge clk);
    #1;
    check("reset holds q", {5'd0, aluctrl_q}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release capture", {5'd0, aluctrl_q}, 8'd6);
    check("release sticky", {7'd0, err_sticky}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
